// File: rtl/taddr_queue_pkg.sv
// Shared definitions for the translated-address queue.
// The width and depth macros are supplied here when no project-wide definition exists.
`ifndef T_ADDR_SIZE
`define T_ADDR_SIZE 16
`endif
`ifndef TQ_DEPTH
`define TQ_DEPTH 4
`endif

package taddr_queue_pkg;

  // {push, pop} packed together; selects the occupancy update for the cycle.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/taddr_queue_mem.sv
// Depth x width register array: one clocked write port (no reset) and one
// asynchronous read port feeding the first-word-fall-through head.
module taddr_queue_mem #(
  parameter int Width = 16,
  parameter int Depth = 4,
  parameter int PtrW  = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PtrW-1:0]  waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [PtrW-1:0]  raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/taddr_queue.sv
// FIFO between the address translator (no backpressure) and the memory-request
// side: absorbs bursts, drops on overflow, and tracks drops with a sticky flag.
module taddr_queue
  import taddr_queue_pkg::*;
#(
  parameter int TransAddrSize = `T_ADDR_SIZE,
  parameter int Depth         = `TQ_DEPTH,
  parameter int CntSize       = $clog2(Depth) + 1,
  parameter int DropSize      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [TransAddrSize-1:0] taddr_i,
  input  logic                     rdy_i,
  output logic [TransAddrSize-1:0] req_addr_o,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output logic [CntSize-1:0]       count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  input  logic                     clr_ovf_i,
  output logic [DropSize-1:0]      drop_cnt_o
);

  localparam int                  PtrW    = $clog2(Depth);
  localparam logic [CntSize-1:0]  FullCnt = CntSize'(Depth);
  localparam logic [DropSize-1:0] DropMax = '1;

  function automatic logic [DropSize-1:0] sat_inc(input logic [DropSize-1:0] v);
    return (v == DropMax) ? v : v + DropSize'(1);
  endfunction

  logic [PtrW-1:0]          r_wr_ptr;
  logic [PtrW-1:0]          r_rd_ptr;
  logic [CntSize-1:0]       r_count;
  logic                     r_ovf;
  logic [DropSize-1:0]      r_drop_cnt;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;
  logic [TransAddrSize-1:0] w_head;
  q_op_e                    w_op;

  assign full_o      = (r_count == FullCnt);
  assign empty_o     = (r_count == '0);
  assign req_valid_o = !empty_o;
  assign count_o     = r_count;
  assign ovf_o       = r_ovf;
  assign drop_cnt_o  = r_drop_cnt;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign w_pop  = req_valid_o & req_ready_i;
  assign w_push = rdy_i & (!full_o | w_pop);
  assign w_drop = rdy_i & full_o & !w_pop;
  assign w_op   = q_op_e'({w_push, w_pop});

  taddr_queue_mem #(
    .Width (TransAddrSize),
    .Depth (Depth),
    .PtrW  (PtrW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr),
    .wdata_i (taddr_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_head)
  );

  assign req_addr_o = empty_o ? '0 : w_head;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case (w_op)
        Q_PUSH:  r_count <= r_count + CntSize'(1);
        Q_POP:   r_count <= r_count - CntSize'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear has priority over a drop landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr_ovf_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

endmodule

// File: tb/tb_taddr_queue.sv
// Directed bench for taddr_queue (Depth=4, 16-bit addresses).
module tb_taddr_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] taddr_i;
  logic        rdy_i;
  logic [15:0] req_addr_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [2:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        ovf_o;
  logic        clr_ovf_i;
  logic [7:0]  drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  taddr_queue #(
    .TransAddrSize (16),
    .Depth         (4),
    .CntSize       (3),
    .DropSize      (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .taddr_i     (taddr_i),
    .rdy_i       (rdy_i),
    .req_addr_o  (req_addr_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .ovf_o       (ovf_o),
    .clr_ovf_i   (clr_ovf_i),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_full"},  32'(full_o), 32'd0);
    chk({tag, "_valid"}, 32'(req_valid_o), 32'd0);
    chk({tag, "_addr"},  32'(req_addr_o), 32'h0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; taddr_i = '0; rdy_i = 1'b0; req_ready_i = 1'b0; clr_ovf_i = 1'b0;

    // Reset held for 100 cycles
    repeat (100) tick();
    chk_idle("rst");
    chk("rst_ovf",  32'(ovf_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    rst_i = 1'b1;
    tick();

    // Ordered pass-through
    rdy_i = 1'b1; taddr_i = 16'h1000; tick();
    chk("pt_cnt1",  32'(count_o), 32'd1);
    chk("pt_head1", 32'(req_addr_o), 32'h1000);
    taddr_i = 16'h1004; tick();
    taddr_i = 16'h1008; tick();
    rdy_i = 1'b0;
    chk("pt_cnt3", 32'(count_o), 32'd3);
    chk("pt_out0", 32'(req_addr_o), 32'h1000);
    req_ready_i = 1'b1; tick();
    chk("pt_out1", 32'(req_addr_o), 32'h1004);
    chk("pt_cnt2", 32'(count_o), 32'd2);
    tick();
    chk("pt_out2", 32'(req_addr_o), 32'h1008);
    tick();
    chk_idle("pt_end");
    req_ready_i = 1'b0;

    // Overflow: six pushes into four slots
    rdy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      taddr_i = 16'hA000 + 16'(i);
      tick();
      if (i == 3) begin
        chk("ovf_full4", 32'(full_o), 32'd1);
        chk("ovf_nodrop", 32'(drop_cnt_o), 32'd0);
      end
    end
    rdy_i = 1'b0;
    chk("ovf_flag", 32'(ovf_o), 32'd1);
    chk("ovf_drops", 32'(drop_cnt_o), 32'd2);
    chk("ovf_cnt", 32'(count_o), 32'd4);
    req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", 32'(req_addr_o), 32'hA000 + 32'(i));
      tick();
    end
    chk_idle("ovf_end");
    req_ready_i = 1'b0;
    clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
    chk("clr_ovf", 32'(ovf_o), 32'd0);
    chk("clr_drop", 32'(drop_cnt_o), 32'd0);

    // Full with simultaneous push and pop
    rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      taddr_i = 16'hB000 + 16'(i);
      tick();
    end
    chk("fp_full", 32'(full_o), 32'd1);
    taddr_i = 16'hB004; req_ready_i = 1'b1; tick();
    rdy_i = 1'b0;
    chk("fp_cnt", 32'(count_o), 32'd4);
    chk("fp_ovf", 32'(ovf_o), 32'd0);
    chk("fp_drop", 32'(drop_cnt_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("fp_drain", 32'(req_addr_o), 32'hB000 + 32'(i));
      tick();
    end
    chk_idle("fp_end");
    req_ready_i = 1'b0;

    // Wrap-around at one push and one pop per cycle
    rdy_i = 1'b1; req_ready_i = 1'b1;
    taddr_i = 16'hC000; tick();
    chk("wr_cnt0", 32'(count_o), 32'd1);
    chk("wr_out0", 32'(req_addr_o), 32'hC000);
    for (int i = 1; i < 10; i++) begin
      taddr_i = 16'hC000 + 16'(i);
      tick();
      chk("wr_cnt", 32'(count_o), 32'd1);
      chk("wr_out", 32'(req_addr_o), 32'hC000 + 32'(i));
    end
    rdy_i = 1'b0; tick();
    chk_idle("wr_end");
    req_ready_i = 1'b0;

    // Mid-operation asynchronous reset
    rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      taddr_i = 16'hD000 + 16'(i);
      tick();
    end
    rdy_i = 1'b0;
    chk("mr_cnt3", 32'(count_o), 32'd3);
    chk("mr_head", 32'(req_addr_o), 32'hD000);
    rst_i = 1'b0;
    #2;
    chk_idle("mr_async");
    rst_i = 1'b1;
    tick();
    chk_idle("mr_after");

    // Saturating drop counter, then clear racing a drop
    rdy_i = 1'b1;
    for (int i = 0; i < 304; i++) begin
      taddr_i = 16'hE000 + 16'(i);
      tick();
    end
    chk("sat_drop", 32'(drop_cnt_o), 32'd255);
    chk("sat_ovf", 32'(ovf_o), 32'd1);
    chk("sat_cnt", 32'(count_o), 32'd4);
    clr_ovf_i = 1'b1; tick();
    clr_ovf_i = 1'b0; rdy_i = 1'b0;
    chk("clrdrop_ovf", 32'(ovf_o), 32'd0);
    chk("clrdrop_cnt", 32'(drop_cnt_o), 32'd0);
    chk("sat_head", 32'(req_addr_o), 32'hE000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
